// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative EX-stage multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // RV32M multiply selectors (funct3[2] = 0 covers the multiply group)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // Decode constants used upstream to form mul_en
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam int MULT_STEPS = 4;

endpackage

// File: rtl/mult_slice_pp.sv
// Combinational partial product of the multiplicand and one multiplier slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module mult_slice_pp #(
    parameter int A_W = 32,
    parameter int S_W = 8
) (
    input  logic [A_W-1:0]     a,
    input  logic [S_W-1:0]     b_slice,
    output logic [A_W+S_W-1:0] pp
);

    // Both operands zero-extended to the full product width before multiplying
    always_comb begin
        pp = {{S_W{1'b0}}, a} * {{A_W{1'b0}}, b_slice};
    end

endmodule

// File: rtl/ex_mult_seq.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), one 8-bit multiplier slice per cycle.
// Latency: 5 stall cycles (latch + 4 steps), result in 6th cycle; MULT_EARLY_OUT_EN ends early when upper slices are zero.
// Backpressure: raises stall_req while busy so the hazard unit freezes PC, IF/ID and ID/EX.
module ex_mult_seq
    import mult_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              mul_en,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              stall_req,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam int STEPS = DATA_W / SLICE_W;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int ACC_W = 2 * DATA_W;
    localparam int PP_W  = DATA_W + SLICE_W;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   a_mag_q, a_mag_d;
    logic [DATA_W-1:0]   b_mag_q, b_mag_d;
    logic                neg_q, neg_d;
    logic [2:0]          f3_q, f3_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic                sign_a, sign_b;
    logic [SLICE_W-1:0]  b_slice;
    logic [PP_W-1:0]     pp;
    logic [ACC_W-1:0]    pp_shifted;
    logic [DATA_W-1:0]   b_rem;
    logic                last_step;
    logic [ACC_W-1:0]    acc_signed;
    logic [DATA_W-1:0]   result_sel;

    mult_slice_pp #(
        .A_W (DATA_W),
        .S_W (SLICE_W)
    ) u_slice_pp (
        .a       (a_mag_q),
        .b_slice (b_slice),
        .pp      (pp)
    );

    // Datapath helpers: operand signs, current slice, shifted partial product, final selection
    always_comb begin
        sign_a     = ((funct3 == F3_MULH) || (funct3 == F3_MULHSU)) && op_a[DATA_W-1];
        sign_b     = (funct3 == F3_MULH) && op_b[DATA_W-1];
        b_slice    = SLICE_W'(b_mag_q >> (int'(cnt_q) * SLICE_W));
        pp_shifted = {{(ACC_W-PP_W){1'b0}}, pp} << (int'(cnt_q) * SLICE_W);
        // Multiplier bits above the slice being consumed this cycle
        b_rem      = b_mag_q >> ((int'(cnt_q) + 1) * SLICE_W);
`ifdef MULT_EARLY_OUT_EN
        last_step  = (cnt_q == CNT_W'(STEPS - 1)) || (b_rem == '0);
`else
        last_step  = (cnt_q == CNT_W'(STEPS - 1));
`endif
        acc_signed = neg_q ? (~acc_q + {{(ACC_W-1){1'b0}}, 1'b1}) : acc_q;
        // Low half is sign-agnostic, so MUL takes the raw magnitude product
        result_sel = (f3_q == F3_MUL) ? acc_q[DATA_W-1:0] : acc_signed[ACC_W-1:DATA_W];
    end

    // State register and datapath flops
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            f3_q     <= F3_MUL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            neg_q    <= neg_d;
            f3_q     <= f3_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        neg_d    = neg_q;
        f3_d     = f3_q;
        result_d = result_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mul_en) begin
                        a_mag_d = sign_a ? (~op_a + {{(DATA_W-1){1'b0}}, 1'b1}) : op_a;
                        b_mag_d = sign_b ? (~op_b + {{(DATA_W-1){1'b0}}, 1'b1}) : op_b;
                        neg_d   = sign_a ^ sign_b;
                        f3_d    = funct3;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_d = acc_q + pp_shifted;
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_step) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_d = result_sel;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs: stall while latching or stepping, pulse valid in DONE unless flushed
    always_comb begin
        stall_req    = 1'b0;
        result_valid = 1'b0;
        result       = result_q;
        if (!flush) begin
            case (state_q)
                ST_IDLE: stall_req = mul_en;
                ST_BUSY: stall_req = 1'b1;
                ST_DONE: begin
                    result_valid = 1'b1;
                    result       = result_sel;
                end
                default: stall_req = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mult_seq.sv
// Self-checking bench for ex_mult_seq: directed table, random vs reference model, flush and reset sequences.
// Latency: checks stall count per operation against the expected early-out/fixed latency.
// Backpressure: models the hazard unit by holding mul_en until result_valid.
module tb_ex_mult_seq;
    import mult_pkg::*;

    logic        clk;
    logic        arst_n;
    logic        mul_en;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall_req;
    logic [31:0] result;
    logic        result_valid;

    int n_chk;
    int n_err;

    ex_mult_seq dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .mul_en       (mul_en),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .stall_req    (stall_req),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact signed/unsigned 64-bit product per RV32M semantics
    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f3)
            F3_MULH:   p = 64'(sa * sb);
            F3_MULHSU: p = 64'(sa * ub);
            default:   p = {32'b0, a} * {32'b0, b};
        endcase
        return (f3 == F3_MUL) ? p[31:0] : p[63:32];
    endfunction

    // Expected stall cycles: 1 latch cycle plus one per multiplier byte consumed
    function automatic int exp_stalls(input logic [2:0] f3, input logic [31:0] b);
        logic [31:0] bm;
        int steps;
        bm = (f3 == F3_MULH && b[31]) ? (0 - b) : b;
        steps = 4;
`ifdef MULT_EARLY_OUT_EN
        steps = 1;
        for (int k = 1; k < 4; k++)
            if ((bm >> (8 * k)) != 0) steps = k + 1;
`endif
        if (bm == 32'hFFFF_FFFF) steps = steps; // magnitude range is full 32 bits
        return 1 + steps;
    endfunction

    // Drive one multiply with mul_en held until result_valid; returns result and stall count
    task automatic run_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int stalls, output bit got);
        mul_en = 1'b1; funct3 = f3; op_a = a; op_b = b;
        stalls = 0; got = 1'b0; res = '0;
        for (int c = 0; c < 20 && !got; c++) begin
            #3;
            if (result_valid) begin
                got = 1'b1;
                res = result;
                if (stall_req) stalls = stalls + 100;
            end else if (stall_req) begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        mul_en = 1'b0;
    endtask

    task automatic do_case(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int st;
        bit got;
        run_mul(f3, a, b, res, st, got);
        chk({name, "_valid_seen"}, 64'(got), 64'd1);
        chk({name, "_result"}, 64'(res), 64'(exp));
        chk({name, "_stalls"}, 64'(st), 64'(exp_stalls(f3, b)));
        // Cycle after DONE: idle, no retrigger, result held
        #3;
        chk({name, "_idle_stall"}, 64'(stall_req), 64'd0);
        chk({name, "_idle_valid"}, 64'(result_valid), 64'd0);
        chk({name, "_hold"}, 64'(result), 64'(exp));
        @(posedge clk); #1;
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        int          saw_valid;
        n_chk = 0; n_err = 0;
        arst_n = 1'b0; mul_en = 1'b0; funct3 = F3_MUL; op_a = '0; op_b = '0; flush = 1'b0;

        vecs[0] = '{F3_MUL,    32'd7,          32'd6,          32'd42};
        vecs[1] = '{F3_MULH,   32'hFFFF_FFFE,  32'h0000_0003,  32'hFFFF_FFFF};
        vecs[2] = '{F3_MUL,    32'hFFFF_FFFE,  32'h0000_0003,  32'hFFFF_FFFA};
        vecs[3] = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[4] = '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[5] = '{F3_MUL,    32'd1000,       32'd5,          32'd5000};
        vecs[6] = '{F3_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
        vecs[7] = '{F3_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[8] = '{F3_MULH,   32'h0000_0005,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[9] = '{F3_MULHU,  32'h0001_0000,  32'h0001_0000,  32'h0000_0001};

        // Reset state
        #12;
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++)
            do_case($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Flush in the third BUSY cycle
        mul_en = 1'b1; funct3 = F3_MUL; op_a = 32'd5; op_b = 32'h0100_0005;
        #3 chk("fl_latch_stall", 64'(stall_req), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        #3;
        chk("fl_stall_drop", 64'(stall_req), 64'd0);
        chk("fl_no_valid", 64'(result_valid), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; mul_en = 1'b0;
        saw_valid = 0;
        for (int c = 0; c < 6; c++) begin
            #3;
            if (result_valid || stall_req) saw_valid++;
            @(posedge clk); #1;
        end
        chk("fl_quiet_after", 64'(saw_valid), 64'd0);
        do_case("fl_next_mul", F3_MUL, 32'd3, 32'd3, 32'd9);

        // Asynchronous reset in the middle of BUSY
        mul_en = 1'b1; funct3 = F3_MULHU; op_a = 32'h1234_5678; op_b = 32'h0100_0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mul_en = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        chk("ar_stall", 64'(stall_req), 64'd0);
        chk("ar_valid", 64'(result_valid), 64'd0);
        chk("ar_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        do_case("ar_mul", F3_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);
        do_case("ar_mulhu", F3_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1);

        // Random operands against the reference model; small multipliers exercise early-out
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(3, 0));
            ra = $urandom;
            case ($urandom_range(3, 0))
                0:       rb = 32'($urandom_range(255, 0));
                1:       rb = 32'($urandom_range(65535, 0));
                default: rb = $urandom;
            endcase
            do_case($sformatf("rnd%0d", i), rf, ra, rb, ref_mul(rf, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
